data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- CORE_COUNT, 4, number of requesting cores.
- REG_WIDTH, 12, data word width.
- DATA_MEM_ADDR_WIDTH, 12, data memory address width.
- MAX_BURST, 4, maximum consecutive beats per grant.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- req, in, CORE_COUNT, per-core access request.
- wr_en, in, CORE_COUNT, per-core write qualifier.
- addr, in, CORE_COUNT*DATA_MEM_ADDR_WIDTH, packed per-core addresses; core i uses slice i.
- wdata, in, CORE_COUNT*REG_WIDTH, packed per-core write data.
- gnt, out, CORE_COUNT, one-hot beat accepted this cycle.
- rvalid, out, CORE_COUNT, one-hot read data valid.
- rdata, out, REG_WIDTH, read data broadcast to all cores.
- mem_addr, out, DATA_MEM_ADDR_WIDTH, memory address.
- mem_wdata, out, REG_WIDTH, memory write data.
- mem_wr_en, out, 1, memory write strobe.
- mem_rdata, in, REG_WIDTH, synchronous-read memory output (1-cycle latency).

Function
REQ-004 gnt SHALL be combinational, one-hot or zero, and asserted only for a core whose req is high.
REQ-005 In a granted cycle, mem_addr, mem_wdata and mem_wr_en SHALL be driven combinationally from the granted core's addr, wdata and wr_en. With no grant, mem_wr_en SHALL be 0 and mem_addr SHALL hold its last value.
REQ-006 A granted beat with wr_en=0 SHALL assert rvalid for that core exactly 1 cycle later, with rdata equal to mem_rdata. A write beat SHALL never assert rvalid.
REQ-007 FSM states:
- IDLE to BURST: any req high. Select the owner by round-robin, starting from the core after the last owner.
- BURST to BURST: owner req still high and burst count < MAX_BURST.
- BURST to IDLE: owner req low, or MAX_BURST beats done. In the same cycle, select a new owner combinationally if any other req is high, so there is no bubble.
REQ-008 The burst counter SHALL be $clog2(MAX_BURST)+1 bits wide. It SHALL reset to 1 on every owner change and increment on each granted beat.
REQ-009 After a MAX_BURST expiry, the expiring owner SHALL have the lowest priority in the next selection. If it is the only requester, it SHALL be re-granted without a gap cycle.
REQ-010 The round-robin pointer SHALL wrap from CORE_COUNT-1 to 0.
REQ-011 If all req inputs are simultaneously high, the cores SHALL be served in order last_owner+1, +2, ... with no starvation. The worst-case wait SHALL be (CORE_COUNT-1)*MAX_BURST cycles.
REQ-012 A read accepted in the last beat of a burst SHALL still return rvalid to its issuing core, even if the grant has moved to another core.

Reset
REQ-013 While rst is high:
- state SHALL be IDLE;
- the round-robin pointer SHALL be CORE_COUNT-1, so core 0 wins first;
- gnt, rvalid and mem_wr_en SHALL be 0;
- rdata, mem_addr and mem_wdata SHALL be 0;
- any pending rvalid SHALL be discarded.
REQ-014 Reset asserted mid-burst SHALL abort the burst immediately with no further memory strobes. Arbitration SHALL resume on the first clk edge after rst deasserts.

Structure
REQ-015 Shared package: the arbiter FSM state enum, and the CORE_COUNT, REG_WIDTH and DATA_MEM_ADDR_WIDTH defaults (the same values used by processor).
REQ-016 One sub-module: rr_priority_picker (combinational round-robin one-hot select from req and pointer). All registers SHALL stay in data_mem_arbiter.

Verification
REQ-017 Directed scenarios the bench SHALL cover, one per line: stimulus -> required response.
- Reset, then only core 2 reads address 0x005 -> gnt=0100 in cycle 0; rvalid=0100 and rdata=mem[5] in cycle 1.
- All 4 cores hold req for 20 cycles -> grants come in blocks of 4 beats in order 0,1,2,3,0; no gap cycles; each core gets 4 consecutive beats.
- Core 1 writes 0xABC to 0x010, then core 3 reads 0x010 in the next cycle -> mem_wr_en pulses once; core 3 rvalid returns 0xABC.
- Core 0 requests alone for 9 cycles -> 9 consecutive grants (bursts re-granted per REQ-009); rvalid follows each read by 1 cycle.
- Core 1 issues a read in its 4th beat while core 2 is waiting -> next cycle: gnt=0100 and rvalid=0010 concurrently.
- rst asserted mid-burst of core 3 -> gnt, mem_wr_en and rvalid go 0 immediately; after release, core 0 wins first.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared data memory arbiter definitions: FSM state encoding and the
// core/word/address sizing defaults used across the processor.
package data_mem_arbiter_pkg;

   localparam int CORE_COUNT_DEF = 4;
   localparam int REG_WIDTH_DEF = 12;
   localparam int DATA_MEM_ADDR_WIDTH_DEF = 12;
   localparam int MAX_BURST_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arbState_t;

endpackage

// File: rtl/data_mem_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: one-hot select of the first requester
// after ptr, wrapping; ptr itself is the lowest priority.
// Ports: req (requests), ptr (last owner), pick (one-hot), pickIdx (index).
module rr_priority_picker #(
   parameter int N = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  pick,
   output logic [PW-1:0] pickIdx
);

   logic [PW-1:0] idx;

   // Walk from the lowest to the highest priority so the last hit wins.
   always_comb begin
      pick = '0;
      pickIdx = '0;
      idx = '0;
      for (int k = N; k >= 1; k--) begin
         idx = PW'((int'(ptr) + k) % N);
         if (req[idx]) begin
            pick = '0;
            pick[idx] = 1'b1;
            pickIdx = idx;
         end
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin burst arbiter giving CORE_COUNT cores access to one
// synchronous data memory. Ports: per-core req/wr_en/addr/wdata in,
// gnt/rvalid/rdata out; mem_addr/mem_wdata/mem_wr_en/mem_rdata to memory.
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int CORE_COUNT = CORE_COUNT_DEF,
   parameter int REG_WIDTH = REG_WIDTH_DEF,
   parameter int DATA_MEM_ADDR_WIDTH = DATA_MEM_ADDR_WIDTH_DEF,
   parameter int MAX_BURST = MAX_BURST_DEF
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [CORE_COUNT-1:0]                     req,
   input  logic [CORE_COUNT-1:0]                     wr_en,
   input  logic [CORE_COUNT*DATA_MEM_ADDR_WIDTH-1:0] addr,
   input  logic [CORE_COUNT*REG_WIDTH-1:0]           wdata,
   output logic [CORE_COUNT-1:0]                     gnt,
   output logic [CORE_COUNT-1:0]                     rvalid,
   output logic [REG_WIDTH-1:0]                      rdata,
   output logic [DATA_MEM_ADDR_WIDTH-1:0]            mem_addr,
   output logic [REG_WIDTH-1:0]                      mem_wdata,
   output logic                                      mem_wr_en,
   input  logic [REG_WIDTH-1:0]                      mem_rdata
);

   localparam int PW = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
   localparam int CW = $clog2(MAX_BURST) + 1;
   localparam int AW = DATA_MEM_ADDR_WIDTH;
   localparam int RW = REG_WIDTH;

   arbState_t state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] pickIdx;
   logic [PW-1:0] gntIdx;
   logic [CW-1:0] beatCnt;
   logic [CORE_COUNT-1:0] pick;
   logic [CORE_COUNT-1:0] ptrHot;
   logic [CORE_COUNT-1:0] rvalidQ;
   logic [AW-1:0] lastAddr;
   logic [RW-1:0] lastWdata;
   logic hold;
   logic gntVld;

   // ptr doubles as the current owner while in BURST, so one picker
   // serves both the idle start and the no-bubble handoff.
   rr_priority_picker #(.N(CORE_COUNT)) uPicker (
      .req     (req),
      .ptr     (ptr),
      .pick    (pick),
      .pickIdx (pickIdx)
   );

   always_comb begin
      ptrHot = '0;
      ptrHot[ptr] = 1'b1;
      hold = (state == BURST) && req[ptr] && (beatCnt < CW'(MAX_BURST));
      gnt = '0;
      gntIdx = ptr;
      gntVld = 1'b0;
      if (!rst) begin
         if (hold) begin
            gnt = ptrHot;
            gntVld = 1'b1;
         end else if (|pick) begin
            gnt = pick;
            gntIdx = pickIdx;
            gntVld = 1'b1;
         end
      end
   end

   assign mem_addr = gntVld ? addr[int'(gntIdx)*AW +: AW] : lastAddr;
   assign mem_wdata = gntVld ? wdata[int'(gntIdx)*RW +: RW] : lastWdata;
   assign mem_wr_en = gntVld & wr_en[gntIdx];
   assign rvalid = rvalidQ;
   assign rdata = (|rvalidQ) ? mem_rdata : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr <= PW'(CORE_COUNT - 1);
         beatCnt <= CW'(1);
         rvalidQ <= '0;
         lastAddr <= '0;
         lastWdata <= '0;
      end else begin
         // Tagged by core, so a read in a burst's last beat still returns.
         rvalidQ <= gnt & ~wr_en;
         if (gntVld) begin
            state <= BURST;
            lastAddr <= mem_addr;
            lastWdata <= mem_wdata;
            if (hold) begin
               beatCnt <= beatCnt + CW'(1);
            end else begin
               ptr <= pickIdx;
               beatCnt <= CW'(1);
            end
         end else begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a synchronous memory model.
// Ports: none (top-level bench).
module tb_data_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] req = '0;
   logic [3:0] wrEn = '0;
   logic [11:0] tAddr [4];
   logic [11:0] tWdata [4];
   logic [47:0] addrBus;
   logic [47:0] wdataBus;
   logic [3:0] gnt;
   logic [3:0] rvalid;
   logic [11:0] rdata;
   logic [11:0] mem_addr;
   logic [11:0] mem_wdata;
   logic mem_wr_en;
   logic [11:0] mem_rdata = '0;

   logic [11:0] store [4096];
   bit written [4096];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign addrBus = {tAddr[3], tAddr[2], tAddr[1], tAddr[0]};
   assign wdataBus = {tWdata[3], tWdata[2], tWdata[1], tWdata[0]};

   data_mem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .wr_en     (wrEn),
      .addr      (addrBus),
      .wdata     (wdataBus),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wr_en (mem_wr_en),
      .mem_rdata (mem_rdata)
   );

   function automatic logic [11:0] memInit(int a);
      return 12'((a * 7 + 3) & 'hfff);
   endfunction

   always @(posedge clk) begin
      if (mem_wr_en) begin
         store[mem_addr] <= mem_wdata;
         written[mem_addr] <= 1'b1;
      end
      mem_rdata <= written[mem_addr] ? store[mem_addr]
                                     : memInit(int'(mem_addr));
   end

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      wrEn = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      req = 4'hF;
      wrEn = 4'hF;
      for (int i = 0; i < 4; i++) begin
         tAddr[i] = 12'h0A0 + 12'(i);
         tWdata[i] = 12'h5A0 + 12'(i);
      end
      #1;
      checks++;
      if (gnt !== 4'b0000) begin
         failures++;
         $display("FAIL reset_gnt got=%b exp=0000", gnt);
      end
      checks++;
      if (mem_wr_en !== 1'b0) begin
         failures++;
         $display("FAIL reset_wr got=%b exp=0", mem_wr_en);
      end
      checks++;
      if (mem_addr !== 12'h000 || mem_wdata !== 12'h000) begin
         failures++;
         $display("FAIL reset_mem addr=%h wdata=%h exp=000", mem_addr,
                  mem_wdata);
      end
      @(negedge clk);
      checks++;
      if (rvalid !== 4'b0000 || rdata !== 12'h000) begin
         failures++;
         $display("FAIL reset_rvalid rvalid=%b rdata=%h exp=0000/000", rvalid,
                  rdata);
      end
   endtask

   task automatic test_single_read();
      doReset();
      req = 4'b0100;
      wrEn = 4'b0000;
      tAddr[2] = 12'h005;
      #1;
      checks++;
      if (gnt !== 4'b0100 || mem_addr !== 12'h005) begin
         failures++;
         $display("FAIL single_gnt gnt=%b addr=%h exp=0100/005", gnt,
                  mem_addr);
      end
      @(negedge clk);
      req = 4'b0000;
      #1;
      checks++;
      if (rvalid !== 4'b0100 || rdata !== 12'h026) begin
         failures++;
         $display("FAIL single_rvalid rvalid=%b rdata=%h exp=0100/026",
                  rvalid, rdata);
      end
      checks++;
      if (gnt !== 4'b0000 || mem_addr !== 12'h005 || mem_wr_en !== 1'b0) begin
         failures++;
         $display("FAIL single_idle gnt=%b addr=%h wr=%b exp=0000/005/0", gnt,
                  mem_addr, mem_wr_en);
      end
      @(negedge clk);
      #1;
      checks++;
      if (rvalid !== 4'b0000) begin
         failures++;
         $display("FAIL single_once rvalid=%b exp=0000", rvalid);
      end
   endtask

   task automatic test_round_robin();
      int owner;
      int prevOwner;
      doReset();
      for (int i = 0; i < 4; i++) tAddr[i] = 12'h100 + 12'(i);
      req = 4'hF;
      wrEn = 4'h0;
      prevOwner = 0;
      for (int c = 0; c < 20; c++) begin
         owner = (c / 4) % 4;
         #1;
         checks++;
         if (gnt !== 4'(1 << owner)) begin
            failures++;
            $display("FAIL rr_gnt cycle=%0d got=%b exp=%b", c, gnt,
                     4'(1 << owner));
         end
         if (c > 0) begin
            checks++;
            if (rvalid !== 4'(1 << prevOwner) ||
                rdata !== memInit(256 + prevOwner)) begin
               failures++;
               $display("FAIL rr_rvalid cycle=%0d rvalid=%b rdata=%h", c,
                        rvalid, rdata);
            end
         end
         prevOwner = owner;
         @(negedge clk);
      end
      req = 4'h0;
      #1;
      checks++;
      if (rvalid !== 4'b0001 || gnt !== 4'b0000) begin
         failures++;
         $display("FAIL rr_tail rvalid=%b gnt=%b exp=0001/0000", rvalid, gnt);
      end
      @(negedge clk);
   endtask

   task automatic test_burst_handoff();
      logic [3:0] expGnt [5];
      expGnt = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
      doReset();
      req = 4'b0110;
      wrEn = 4'b0000;
      tAddr[1] = 12'h030;
      tAddr[2] = 12'h031;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if (gnt !== expGnt[c]) begin
            failures++;
            $display("FAIL handoff_gnt cycle=%0d got=%b exp=%b", c, gnt,
                     expGnt[c]);
         end
         if (c == 4) begin
            checks++;
            if (rvalid !== 4'b0010 || rdata !== 12'h153) begin
               failures++;
               $display("FAIL handoff_rvalid rvalid=%b rdata=%h exp=0010/153",
                        rvalid, rdata);
            end
         end
         @(negedge clk);
      end
      req = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      doReset();
      req = 4'b0010;
      wrEn = 4'b0010;
      tAddr[1] = 12'h010;
      tWdata[1] = 12'hABC;
      #1;
      checks++;
      if (gnt !== 4'b0010 || mem_wr_en !== 1'b1 || mem_addr !== 12'h010 ||
          mem_wdata !== 12'hABC) begin
         failures++;
         $display("FAIL wr_beat gnt=%b wr=%b addr=%h wdata=%h", gnt,
                  mem_wr_en, mem_addr, mem_wdata);
      end
      @(negedge clk);
      req = 4'b1000;
      wrEn = 4'b0000;
      tAddr[3] = 12'h010;
      #1;
      checks++;
      if (gnt !== 4'b1000 || mem_wr_en !== 1'b0 || rvalid !== 4'b0000) begin
         failures++;
         $display("FAIL rd_beat gnt=%b wr=%b rvalid=%b exp=1000/0/0000", gnt,
                  mem_wr_en, rvalid);
      end
      @(negedge clk);
      req = 4'b0000;
      #1;
      checks++;
      if (rvalid !== 4'b1000 || rdata !== 12'hABC || mem_wr_en !== 1'b0) begin
         failures++;
         $display("FAIL wr_rd_data rvalid=%b rdata=%h wr=%b exp=1000/abc/0",
                  rvalid, rdata, mem_wr_en);
      end
      @(negedge clk);
   endtask

   task automatic test_solo();
      doReset();
      req = 4'b0001;
      wrEn = 4'b0000;
      for (int c = 0; c < 10; c++) begin
         if (c < 9) tAddr[0] = 12'(c);
         else req = 4'b0000;
         #1;
         checks++;
         if (gnt !== ((c < 9) ? 4'b0001 : 4'b0000)) begin
            failures++;
            $display("FAIL solo_gnt cycle=%0d got=%b", c, gnt);
         end
         if (c > 0) begin
            checks++;
            if (rvalid !== 4'b0001 || rdata !== memInit(c - 1)) begin
               failures++;
               $display("FAIL solo_rvalid cycle=%0d rvalid=%b rdata=%h exp=%h",
                        c, rvalid, rdata, memInit(c - 1));
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      doReset();
      req = 4'b1000;
      wrEn = 4'b0000;
      tAddr[3] = 12'h020;
      #1;
      checks++;
      if (gnt !== 4'b1000) begin
         failures++;
         $display("FAIL mid_first got=%b exp=1000", gnt);
      end
      @(negedge clk);
      wrEn = 4'b1000;
      tWdata[3] = 12'h555;
      #1;
      checks++;
      if (gnt !== 4'b1000 || mem_wr_en !== 1'b1 || rvalid !== 4'b1000) begin
         failures++;
         $display("FAIL mid_pre gnt=%b wr=%b rvalid=%b exp=1000/1/1000", gnt,
                  mem_wr_en, rvalid);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0000 || mem_wr_en !== 1'b0 || rvalid !== 4'b0000 ||
          rdata !== 12'h000) begin
         failures++;
         $display("FAIL mid_abort gnt=%b wr=%b rvalid=%b rdata=%h", gnt,
                  mem_wr_en, rvalid, rdata);
      end
      @(negedge clk);
      #1;
      checks++;
      if (written[12'h020] !== 1'b0) begin
         failures++;
         $display("FAIL mid_nostrobe written=%b exp=0", written[12'h020]);
      end
      @(negedge clk);
      rst = 1'b0;
      req = 4'hF;
      wrEn = 4'h0;
      #1;
      checks++;
      if (gnt !== 4'b0001) begin
         failures++;
         $display("FAIL mid_resume got=%b exp=0001", gnt);
      end
      @(negedge clk);
      req = 4'h0;
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         tAddr[i] = '0;
         tWdata[i] = '0;
      end
      test_reset();
      test_single_read();
      test_round_robin();
      test_burst_handoff();
      test_write_read();
      test_solo();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
